// File: rtl/gpr_ctrl_pkg.sv
// Shared constants for the gpr arbiter: FSM state encodings, default bus widths
// and the timeout-counter width helper.
package gpr_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t ISSUE    = 3'd1;
  localparam state_t WAIT_LO  = 3'd2;
  localparam state_t WAIT_HI  = 3'd3;
  localparam state_t COMPLETE = 3'd4;

  localparam int GPR_DATA_W = 16;
  localparam int GPR_ADDR_W = 16;

  // Timer holds values up to limit, never narrower than 4 bits.
  function automatic int tmr_width(input int limit);
    int w;
    w = 4;
    while ((1 << w) <= limit) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr+1,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!valid && req[j] && (j == ((int'(ptr) + k) % NUM_REQ))) begin
          valid      = 1'b1;
          winner[j]  = 1'b1;
          winner_idx = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/gpr_arbiter.sv
// Round-robin sharing of the single-port gpr bank, one transaction at a time.
// Optional watchdog on the rdy handshake when GPR_ARB_TIMEOUT_EN is defined.
//
// state    | meaning
// IDLE     | waiting for a request while gpr is ready
// ISSUE    | first cycle of cs, write/oe from the latched request
// WAIT_LO  | cs held, waiting for gpr to drop rdy
// WAIT_HI  | cs held, capturing read data until rdy returns
// COMPLETE | done pulse to the granted requester, gnt cleared on exit
module gpr_arbiter
  import gpr_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = GPR_DATA_W,
  parameter int ADDR_W         = GPR_ADDR_W,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      gpr_cs,
  output logic                      gpr_write,
  output logic [ADDR_W-1:0]         gpr_address,
  output logic [DATA_W-1:0]         gpr_wdata,
  output logic                      gpr_wdata_oe,
  input  logic [DATA_W-1:0]         gpr_rdata,
  input  logic                      gpr_rdy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("gpr_arbiter: unsupported parameter set");
  end

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic                cur_wr;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wdata;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                waiting;
  logic                in_xact;
  logic                tmo;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req),
    .ptr        (ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  assign waiting = (state == WAIT_LO) || (state == WAIT_HI);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      ptr       <= IDX_W'(NUM_REQ - 1);
      cur_wr    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid && gpr_rdy) begin
            gnt       <= pick_onehot;
            ptr       <= pick_idx;
            cur_wr    <= req_wr[pick_idx];
            cur_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            cur_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
            state     <= ISSUE;
          end
        end
        ISSUE: state <= WAIT_LO;
        WAIT_LO: begin
          if (tmo) begin
            state <= COMPLETE;
            if (!cur_wr) rdata <= '0;
          end else if (!gpr_rdy) begin
            state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (gpr_rdy) begin
            state <= COMPLETE;
          end else if (tmo) begin
            state <= COMPLETE;
            if (!cur_wr) rdata <= '0;
          end else if (!cur_wr) begin
            rdata <= gpr_rdata;
          end
        end
        COMPLETE: begin
          gnt   <= '0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // cs falls in the same cycle rdy returns so the gpr never sees a second strobe.
  assign in_xact      = (state == ISSUE) || (state == WAIT_LO) ||
                        ((state == WAIT_HI) && !gpr_rdy);
  assign gpr_cs       = in_xact;
  assign gpr_write    = in_xact && cur_wr;
  assign gpr_wdata_oe = in_xact && cur_wr;
  assign gpr_address  = cur_addr;
  assign gpr_wdata    = cur_wdata;
  assign done         = (state == COMPLETE) ? gnt : '0;

`ifdef GPR_ARB_TIMEOUT_EN
  localparam int TMR_W = tmr_width(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] tmr;
  logic             tmo_flag;

  // Down-counter loaded in ISSUE; terminal count on the last allowed wait cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr      <= '0;
      tmo_flag <= 1'b0;
    end else if (state == ISSUE) begin
      tmr      <= TMR_W'(TIMEOUT_CYCLES - 1);
      tmo_flag <= 1'b0;
    end else if (waiting) begin
      if (tmo) tmo_flag <= 1'b1;
      else if (tmr != '0) tmr <= tmr - 1'b1;
    end
  end

  assign tmo = waiting && (tmr == '0) && !((state == WAIT_HI) && gpr_rdy);
  assign err = (state == COMPLETE) && tmo_flag;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_arbiter.sv
// Directed bench for gpr_arbiter with a small negedge-driven gpr bus model.
module tb_gpr_arbiter;

  localparam int NR = 2;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 15;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req, req_wr, gnt, done;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rdata, gpr_wdata, gpr_rdata;
  logic              err, gpr_cs, gpr_write, gpr_wdata_oe, gpr_rdy;
  logic [AW-1:0]     gpr_address;

  logic              bfm_rdy, bfm_stall, bfm_hang;
  int                bfm_cnt, bfm_lat;
  logic [DW-1:0]     mem [8];
  int                n_chk, n_fail, n_done;

  gpr_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .gpr_cs(gpr_cs), .gpr_write(gpr_write), .gpr_address(gpr_address),
    .gpr_wdata(gpr_wdata), .gpr_wdata_oe(gpr_wdata_oe), .gpr_rdata(gpr_rdata),
    .gpr_rdy(gpr_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign gpr_rdy = bfm_rdy & ~bfm_stall;

  // gpr model: accepts a strobe, drops rdy for bfm_lat cycles (forever if hung)
  always @(negedge clk) begin
    if (!rst_n) begin
      bfm_rdy = 1'b1;
      bfm_cnt = 0;
    end else if (bfm_cnt != 0) begin
      bfm_cnt = bfm_cnt - 1;
      if (bfm_cnt == 0 && !bfm_hang) bfm_rdy = 1'b1;
    end else if (gpr_cs && bfm_rdy) begin
      bfm_rdy = 1'b0;
      bfm_cnt = bfm_lat;
      if (gpr_write && gpr_wdata_oe) mem[gpr_address[2:0]] = gpr_wdata;
      else gpr_rdata = mem[gpr_address[2:0]];
    end
    if (done != '0) n_done = n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_wr[i]           = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Cycles counted from the current cycle until done is seen (bounded).
  task automatic wait_done(input string tag, output int n, output logic [NR-1:0] d);
    logic seen;
    seen = 1'b0;
    n    = 0;
    d    = '0;
    while (!seen && n < 200) begin
      cyc(1);
      n = n + 1;
      if (done != '0) begin
        seen = 1'b1;
        d    = done;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'h1);
  endtask

  logic [NR-1:0] exp_seq [4];
  logic [DW-1:0] exp_rd  [4];
  logic [NR-1:0] d;
  int            n, d0;

  initial begin
    n_chk = 0; n_fail = 0; n_done = 0;
    bfm_rdy = 1'b1; bfm_stall = 1'b0; bfm_hang = 1'b0; bfm_cnt = 0; bfm_lat = 2;
    gpr_rdata = '0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
    rst_n = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    cyc(3);
    chk("rst_gnt",   32'(gnt),          32'h0);
    chk("rst_done",  32'(done),         32'h0);
    chk("rst_rdata", 32'(rdata),        32'h0);
    chk("rst_err",   32'(err),          32'h0);
    chk("rst_cs",    32'(gpr_cs),       32'h0);
    chk("rst_write", 32'(gpr_write),    32'h0);
    chk("rst_oe",    32'(gpr_wdata_oe), 32'h0);
    rst_n = 1'b1;
    cyc(1);

    // 1: single write, rdy low two cycles
    set_req(0, 1'b1, 16'd3, 16'hA5A5);
    req = 2'b01;
    cyc(1);
    chk("t1_gnt",   32'(gnt),          32'h1);
    chk("t1_cs",    32'(gpr_cs),       32'h1);
    chk("t1_write", 32'(gpr_write),    32'h1);
    chk("t1_oe",    32'(gpr_wdata_oe), 32'h1);
    chk("t1_addr",  32'(gpr_address),  32'h3);
    chk("t1_wdata", 32'(gpr_wdata),    32'hA5A5);
    cyc(1);
    chk("t1_wait_lo_cs", 32'(gpr_cs), 32'h1);
    cyc(1);
    @(negedge clk); #1;
    chk("t1_cs_drop",    32'(gpr_cs),    32'h0);
    chk("t1_write_drop", 32'(gpr_write), 32'h0);
    cyc(1);
    chk("t1_done",     32'(done),   32'h1);
    chk("t1_err",      32'(err),    32'h0);
    chk("t1_cs_cmpl",  32'(gpr_cs), 32'h0);
    req = '0;
    cyc(1);
    chk("t1_gnt_clr",  32'(gnt),    32'h0);
    chk("t1_rdata",    32'(rdata),  32'h0);
    chk("t1_mem",      32'(mem[3]), 32'hA5A5);

    // 2: read-back from requester 1
    bfm_lat = 3;
    set_req(1, 1'b0, 16'd3, 16'h0000);
    req = 2'b10;
    cyc(1);
    chk("t2_gnt",   32'(gnt),          32'h2);
    chk("t2_cs",    32'(gpr_cs),       32'h1);
    chk("t2_write", 32'(gpr_write),    32'h0);
    chk("t2_oe",    32'(gpr_wdata_oe), 32'h0);
    wait_done("t2", n, d);
    chk("t2_lat",   32'(n),     32'd4);
    chk("t2_done",  32'(d),     32'h2);
    chk("t2_rdata", 32'(rdata), 32'hA5A5);
    req = '0;
    cyc(2);
    chk("t2_rdata_hold", 32'(rdata), 32'hA5A5);

    // 3: contention after reset alternates starting with requester 0
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    set_req(0, 1'b0, 16'd5, 16'h0000);
    set_req(1, 1'b0, 16'd3, 16'h0000);
    req = 2'b11;
    exp_seq[0] = 2'b01; exp_rd[0] = 16'h1005;
    exp_seq[1] = 2'b10; exp_rd[1] = 16'hA5A5;
    exp_seq[2] = 2'b01; exp_rd[2] = 16'h1005;
    exp_seq[3] = 2'b10; exp_rd[3] = 16'hA5A5;
    for (int i = 0; i < 4; i++) begin
      wait_done("t3", n, d);
      chk($sformatf("t3_done%0d", i),  32'(d),     32'(exp_seq[i]));
      chk($sformatf("t3_rdata%0d", i), 32'(rdata), 32'(exp_rd[i]));
    end
    req = '0;
    cyc(2);

    // 4: gpr busy in IDLE blocks the grant
    bfm_stall = 1'b1;
    req = 2'b01;
    cyc(5);
    chk("t4_no_gnt", 32'(gnt),    32'h0);
    chk("t4_no_cs",  32'(gpr_cs), 32'h0);
    bfm_stall = 1'b0;
    cyc(1);
    chk("t4_gnt", 32'(gnt), 32'h1);
    wait_done("t4", n, d);
    chk("t4_done", 32'(d), 32'h1);
    req = '0;
    cyc(1);

    // 5: reset during WAIT_HI aborts; pointer returns to favour requester 0
    req = 2'b01;
    cyc(1);
    chk("t5_gnt", 32'(gnt), 32'h1);
    cyc(2);
    chk("t5_pre_cs", 32'(gpr_cs), 32'h1);
    d0 = n_done;
    rst_n = 1'b0;
    cyc(1);
    chk("t5_cs",   32'(gpr_cs), 32'h0);
    chk("t5_gnt0", 32'(gnt),    32'h0);
    chk("t5_done", 32'(done),   32'h0);
    cyc(1);
    rst_n = 1'b1;
    req = 2'b11;
    cyc(1);
    chk("t5_first_gnt", 32'(gnt), 32'h1);
    chk("t5_no_done",   32'(n_done), 32'(d0));
    wait_done("t5", n, d);
    chk("t5_done_after", 32'(d), 32'h1);
    req = '0;
    cyc(2);

    // 6: gpr never returns rdy
    bfm_hang = 1'b1;
    req = 2'b01;
    cyc(1);
    chk("t6_gnt", 32'(gnt), 32'h1);
`ifdef GPR_ARB_TIMEOUT_EN
    wait_done("t6", n, d);
    chk("t6_lat",   32'(n),     32'(TO + 1));
    chk("t6_done",  32'(d),     32'h1);
    chk("t6_err",   32'(err),   32'h1);
    chk("t6_rdata", 32'(rdata), 32'h0);
`else
    d0 = n_done;
    cyc(100);
    chk("t6_no_done", 32'(n_done), 32'(d0));
    chk("t6_held",    32'(gnt),    32'h1);
    chk("t6_cs",      32'(gpr_cs), 32'h1);
    chk("t6_err",     32'(err),    32'h0);
`endif
    req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
